// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready pipeline register with stall propagation, flush and occupancy count.
// Optional build macro PIPE_REG_SKID_EN adds a skid register per stage, which registers every ready.
`timescale 1ns/1ps
module pipe_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
`ifdef PIPE_REG_SKID_EN
  localparam int CAP = 2 * DEPTH,
`else
  localparam int CAP = DEPTH,
`endif
  localparam int OCC_W = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] v_r;
  logic [WIDTH-1:0] d_r [DEPTH];
  logic [DEPTH-1:0] up_valid_s;
  logic [WIDTH-1:0] up_data_s [DEPTH];
  logic             in_fire_s;
  logic             out_fire_s;
  logic [OCC_W-1:0] occ_r;

  // Upstream view of every stage: stage 0 sees the input port, stage k sees stage k-1
  always_comb begin
    up_valid_s[0] = in_valid;
    up_data_s[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      up_valid_s[k] = v_r[k-1];
      up_data_s[k]  = d_r[k-1];
    end
  end

`ifdef PIPE_REG_SKID_EN
  logic [DEPTH-1:0] sv_r;
  logic [WIDTH-1:0] sd_r [DEPTH];
  logic [DEPTH:0]   rdy_chain_s;
  logic [DEPTH-1:0] dn_ready_s;
  logic [DEPTH-1:0] up_fire_s;

  // Each stage's downstream ready is the registered "skid empty" of the next stage
  always_comb begin
    rdy_chain_s = {out_ready, ~sv_r};
    dn_ready_s  = rdy_chain_s[DEPTH:1];
    up_fire_s   = up_valid_s & ~sv_r;
  end

  assign in_ready = ~sv_r[0] & ~flush;

  // Main register drains first; a word arriving while main is stalled parks in the skid register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r  <= '0;
      sv_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_r[k]  <= '0;
        sd_r[k] <= '0;
      end
    end else if (flush) begin
      v_r  <= '0;
      sv_r <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (~v_r[k] | dn_ready_s[k]) begin
          if (sv_r[k]) begin
            v_r[k]  <= 1'b1;
            d_r[k]  <= sd_r[k];
            sv_r[k] <= 1'b0;
          end else begin
            v_r[k] <= up_fire_s[k];
            if (up_fire_s[k]) begin
              d_r[k] <= up_data_s[k];
            end
          end
        end else if (up_fire_s[k]) begin
          sv_r[k] <= 1'b1;
          sd_r[k] <= up_data_s[k];
        end
      end
    end
  end
`else
  logic [DEPTH-1:0] adv_s;

  // ready[k] = !v[k] | ready[k+1], unrolled as "out_ready or some stage from k onward is empty"
  always_comb begin : ready_chain
    logic full_tail;
    full_tail = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      full_tail = full_tail & v_r[k];
      adv_s[k]  = out_ready | ~full_tail;
    end
  end

  assign in_ready = adv_s[0] & ~flush;

  // Advancing stages copy their upstream neighbour; stalled stages hold valid and data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_r[k] <= '0;
      end
    end else if (flush) begin
      v_r <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv_s[k]) begin
          v_r[k] <= up_valid_s[k];
          d_r[k] <= up_data_s[k];
        end
      end
    end
  end
`endif

  assign out_valid  = v_r[DEPTH-1] & ~flush;
  assign out_data   = d_r[DEPTH-1];
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  assign occupancy  = occ_r;

  // Occupancy tracks accepted minus delivered words; handshakes keep it within 0..CAP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_r <= '0;
    end else if (flush) begin
      occ_r <= '0;
    end else begin
      occ_r <= occ_r + OCC_W'(in_fire_s) - OCC_W'(out_fire_s);
    end
  end

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised valid/ready pipeline register: a chain of `DEPTH` stages, each holding a `WIDTH`-bit word, with per-stage stall propagation, a synchronous flush and an occupancy count. It generalises the team's fixed 16-bit D flip-flop bank into a flow-controlled pipeline stage. It sits between datapath blocks that need registered timing cuts without dropping or duplicating words under backpressure.

## Interface
- `WIDTH`, 16, data word width in bits (≥1)
- `DEPTH`, 4, number of pipeline stages (≥1)
- `clk`  input  1  clock; all state updates on the rising edge
- `rst_n`  input  1  reset; synchronous, active-low
- `flush`  input  1  synchronously discard all held words
- `in_data`  input  WIDTH  upstream word
- `in_valid`  input  1  upstream word valid
- `in_ready`  output  1  block accepts `in_data` this cycle
- `out_data`  output  WIDTH  word at the last stage
- `out_valid`  output  1  `out_data` valid
- `out_ready`  input  1  downstream accepts `out_data` this cycle
- `occupancy`  output  $clog2(CAP+1)  words currently held; CAP = DEPTH, or 2*DEPTH with `PIPE_REG_SKID_EN`

## Operation
- Transfer rules: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`. A word is accepted or delivered only on a fire.
- Stage k holds `v[k]`, `d[k]`. Stage 0 is the input side; stage DEPTH-1 drives `out_data`/`out_valid`.
- Stage k advances when `ready[k] = !v[k] | ready[k+1]`, with `ready[DEPTH] = out_ready`. On advance: `v[k] <= v[k-1]` (stage 0: `in_valid`), `d[k] <= d[k-1]` (stage 0: `in_data`). A stalled stage holds both `v` and `d`.
- `in_ready = ready[0] & !flush`.
- Ordering: words leave in acceptance order. None are lost or duplicated.
- Bubbles collapse: a valid word advances into any empty downstream stage even while the output stalls.
- Flush:
  - While `flush` = 1, `in_ready` = 0 and `out_valid` = 0, so no fire can occur.
  - On the edge, every `v` and skid-valid bit clears and `occupancy` becomes 0.
  - Data registers keep their contents.
- `occupancy <= occupancy + in_fire - out_fire`, saturating at neither end, since the handshakes prevent overflow and underflow. It is always equal to the popcount of all valid bits.
- Reset (`rst_n` = 0 at an edge):
  - All valid bits, data registers and `occupancy` go to 0.
  - Outputs after the reset edge: `out_valid` = 0, `out_data` = 0, `occupancy` = 0. `in_ready` = 1 once `rst_n` = 1 and `flush` = 0.
  - Reset takes priority over flush and over any in-flight transfer; a word mid-pipeline is dropped.

## Timing
- Latency: a word accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N+DEPTH-1, i.e. DEPTH cycles from presentation to output, when not stalled.
- Throughput: one word per cycle with `out_ready` held 1.
- Without `PIPE_REG_SKID_EN`, `in_ready` depends combinationally on `out_ready` through all stages (a ready chain of length DEPTH).
- `out_valid`, `out_data` and `occupancy` are register outputs. `out_valid` is additionally gated by `flush`.
- Simultaneous `in_fire` and `out_fire` with a full pipe is legal and keeps `occupancy` at CAP.

## Configuration
- `PIPE_REG_SKID_EN` defined: each stage gains a skid register (`sv[k]`, `sd[k]`), and the stage's upstream ready becomes the registered `!sv[k]`.
  - When the downstream stalls while a word arrives, that word lands in the skid register. The main register drains first, then the skid register.
  - No combinational `out_ready`→`in_ready` path exists.
  - CAP = 2*DEPTH; latency is unchanged at DEPTH.
- Not defined: plain stall-chain behaviour as described in Operation; CAP = DEPTH.

## Test plan
- Reset: drive `rst_n` = 0 for 2 cycles with `in_valid` = 1 → `out_valid` = 0, `out_data` = 0, `occupancy` = 0; `in_ready` = 1 on the first cycle after release.
- Streaming, WIDTH=16, DEPTH=4, `out_ready` = 1, inputs 0x0001..0x0010 on consecutive cycles:
  - 0x0001 appears 4 cycles after presentation, then one word per cycle in order.
  - `occupancy` is steady at 4.
- Backpressure: hold `out_ready` = 0 while streaming → `in_ready` drops after CAP accepts (4, or 8 with skid) and `occupancy` = CAP. Release `out_ready` → all words drain in order, none lost.
- Bubble collapse: send 0xA5A5, idle 2 cycles, send 0x5A5A with `out_ready` = 0 → both words sit in the last two stages and `occupancy` = 2.
- Flush mid-stream with `occupancy` = 3:
  - During the flush cycle, `in_ready` = 0 and `out_valid` = 0.
  - Next cycle, `occupancy` = 0. The first word sent after the flush is the next word out.
- DEPTH=1 with random `in_valid`/`out_ready` for 10k cycles, checked against a reference FIFO model → data and order match, and `occupancy` never exceeds CAP.
